// File: rtl/perceptron_pred_core_if.sv
// perceptron_pred_core_if: predict / resolve / flush bundle of the predictor.
// master = host side, slave = predictor core.
interface perceptron_pred_core_if #(
    parameter int PC_W  = 8,
    parameter int SUM_W = 13
);
    logic                    req_valid;
    logic [PC_W-1:0]         req_pc;
    logic                    req_ready;
    logic                    pred_valid;
    logic                    pred_taken;
    logic signed [SUM_W-1:0] pred_sum;
    logic                    resolve_valid;
    logic                    resolve_taken;
    logic                    flush;

    modport master (
        output req_valid, req_pc, resolve_valid, resolve_taken, flush,
        input  req_ready, pred_valid, pred_taken, pred_sum
    );

    modport slave (
        input  req_valid, req_pc, resolve_valid, resolve_taken, flush,
        output req_ready, pred_valid, pred_taken, pred_sum
    );
endinterface

// File: rtl/perceptron_pred_core.sv
// perceptron_pred_core: sequential perceptron branch predictor.
// Ports: clk, rst_n (sync, active-low), bus (predict/resolve/flush),
// busy, init_done (pulse), hist_out (global history, bit 0 newest).
module perceptron_pred_core #(
    parameter int PC_W     = 8,
    parameter int HIST_LEN = 8,
    parameter int WEIGHT_W = 8,
    parameter int NUM_PERC = 16,
    parameter int THETA    = 29,
    parameter int IDX_W    = $clog2(NUM_PERC),
    parameter int SUM_W    = WEIGHT_W + $clog2(HIST_LEN + 1) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    perceptron_pred_core_if.slave bus,
    output logic                  busy,
    output logic                  init_done,
    output logic [HIST_LEN-1:0]   hist_out
);
    localparam int ROW  = HIST_LEN + 1;
    localparam int NENT = NUM_PERC * ROW;
    localparam int AW   = $clog2(NENT);
    localparam int JW   = $clog2(ROW + 1);

    localparam logic [2:0] S_INIT  = 3'd0;
    localparam logic [2:0] S_IDLE  = 3'd1;
    localparam logic [2:0] S_COMP  = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_TRAIN = 3'd4;

    logic [2:0]                 state;
    logic [AW-1:0]              ptr;
    logic [JW-1:0]              jc;
    logic [IDX_W-1:0]           idx;
    logic [HIST_LEN-1:0]        hist;
    logic [HIST_LEN-1:0]        snap;
    logic [HIST_LEN-1:0]        hist_sh;
    logic signed [SUM_W-1:0]    sum;
    logic signed [SUM_W-1:0]    term;
    logic signed [SUM_W-1:0]    w_ext;
    logic [SUM_W-1:0]           mag;
    logic                       res_t;
    logic                       t_in;
    logic                       xbit;
    logic                       need_train;
    logic                       unused_pc;
    logic [HIST_LEN:0]          xs;
    logic [AW-1:0]              addr;
    logic [AW-1:0]              wr_addr;
    logic                       wr_en;
    logic signed [WEIGHT_W-1:0] w_rd;
    logic signed [WEIGHT_W-1:0] w_new;
    logic signed [WEIGHT_W-1:0] wr_data;
    logic signed [WEIGHT_W:0]   wx;
    logic signed [WEIGHT_W-1:0] wt [NENT];

    assign bus.req_ready = (state == S_IDLE);
    assign busy          = (state != S_IDLE);
    assign hist_out      = hist;
    assign unused_pc     = ^bus.req_pc;

    always_comb begin
        addr  = AW'(int'(idx) * ROW + int'(jc));
        // bit 0 is the constant +1 bias input, bit k is hist[k-1]
        xs    = {snap, 1'b1} >> jc;
        xbit  = xs[0];
        w_rd  = wt[addr];
        w_ext = SUM_W'(w_rd);
        term  = xbit ? w_ext : -w_ext;

        // one extra bit catches the +/-1 step leaving the weight range
        wx = {w_rd[WEIGHT_W-1], w_rd};
        if (res_t == xbit)
            wx = wx + (WEIGHT_W+1)'(1);
        else
            wx = wx - (WEIGHT_W+1)'(1);
        if (wx[WEIGHT_W] != wx[WEIGHT_W-1])
            w_new = wx[WEIGHT_W] ? {1'b1, {(WEIGHT_W-1){1'b0}}}
                                 : {1'b0, {(WEIGHT_W-1){1'b1}}};
        else
            w_new = wx[WEIGHT_W-1:0];

        mag = bus.pred_sum[SUM_W-1] ? SUM_W'(-bus.pred_sum)
                                    : SUM_W'(bus.pred_sum);
        need_train = (bus.resolve_taken != bus.pred_taken)
                  || (mag <= SUM_W'(THETA));

        t_in    = (state == S_WAIT) ? bus.resolve_taken : res_t;
        hist_sh = (hist << 1) | HIST_LEN'(t_in);

        wr_en   = 1'b0;
        wr_addr = addr;
        wr_data = w_new;
        if (rst_n) begin
            if (state == S_INIT) begin
                wr_en   = 1'b1;
                wr_addr = ptr;
                wr_data = '0;
            end else if (state == S_TRAIN && !bus.flush) begin
                wr_en = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            wt[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= S_INIT;
            ptr            <= '0;
            jc             <= '0;
            idx            <= '0;
            snap           <= '0;
            hist           <= '0;
            sum            <= '0;
            res_t          <= 1'b0;
            init_done      <= 1'b0;
            bus.pred_valid <= 1'b0;
            bus.pred_taken <= 1'b0;
            bus.pred_sum   <= '0;
        end else begin
            bus.pred_valid <= 1'b0;
            init_done      <= 1'b0;
            case (state)
                S_INIT: begin
                    ptr <= ptr + 1'b1;
                    if (ptr == AW'(NENT - 1)) begin
                        ptr       <= '0;
                        init_done <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                S_IDLE: begin
                    if (bus.req_valid) begin
                        idx   <= bus.req_pc[IDX_W+1:2];
                        snap  <= hist;
                        sum   <= '0;
                        jc    <= '0;
                        state <= S_COMP;
                    end
                end
                S_COMP: begin
                    if (bus.flush) begin
                        state <= S_IDLE;
                    end else if (jc == JW'(ROW)) begin
                        bus.pred_valid <= 1'b1;
                        bus.pred_sum   <= sum;
                        bus.pred_taken <= !sum[SUM_W-1];
                        state          <= S_WAIT;
                    end else begin
                        sum <= sum + term;
                        jc  <= jc + 1'b1;
                    end
                end
                S_WAIT: begin
                    if (bus.flush) begin
                        state <= S_IDLE;
                    end else if (bus.resolve_valid) begin
                        res_t <= bus.resolve_taken;
                        if (need_train) begin
                            jc    <= '0;
                            state <= S_TRAIN;
                        end else begin
                            hist  <= hist_sh;
                            state <= S_IDLE;
                        end
                    end
                end
                S_TRAIN: begin
                    if (bus.flush) begin
                        state <= S_IDLE;
                    end else begin
                        jc <= jc + 1'b1;
                        if (jc == JW'(HIST_LEN)) begin
                            hist  <= hist_sh;
                            state <= S_IDLE;
                        end
                    end
                end
                default: state <= S_INIT;
            endcase
        end
    end
endmodule
